// File: rtl/mod4051_residue_accumulator.sv
// mod4051_residue_accumulator
// Sums a stream of 12-bit partial residues modulo MODULUS and presents the
// final residue of the frame, plus a flag when the term count is not N_TERMS.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   clr          synchronous abort of the current frame and any pending result
//   in_valid     partial residue beat valid
//   in_ready     block accepts a beat this cycle (decoded from state only)
//   in_residue   partial residue, nominally < MODULUS
//   in_last      final beat of a frame
//   res_valid    final residue available
//   res_ready    downstream consumes the result
//   res_value    final residue in [0, MODULUS-1]
//   res_err      frame term count differed from N_TERMS
module mod4051_residue_accumulator #(
    parameter int unsigned MODULUS = 4051,
    parameter int unsigned W       = 12,
    parameter int unsigned N_TERMS = 67,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_residue,
    input  logic         in_last,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_value,
    output logic         res_err
);

    localparam logic [W-1:0]     MOD_W     = W'(MODULUS);
    localparam logic [W:0]       MOD_W1    = (W+1)'(MODULUS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_TERMS = CNT_W'(N_TERMS);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [W-1:0]     acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [W-1:0]     res_value_d;
    logic             res_err_d;

    logic [W-1:0]     norm;
    logic [W:0]       sum;
    logic [W-1:0]     acc_sum;
    logic [CNT_W-1:0] cnt_inc;

    // Datapath: one subtraction normalises any W-bit input since 2^W-1 < 2*MODULUS
    always_comb begin
        norm    = (in_residue >= MOD_W) ? in_residue - MOD_W : in_residue;
        sum     = {1'b0, acc} + {1'b0, norm};
        acc_sum = (sum >= MOD_W1) ? W'(sum - MOD_W1) : W'(sum);
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end

    // Next-state and next-value logic
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        res_value_d = res_value;
        res_err_d   = res_err;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        if (in_last) begin
                            res_value_d = acc_sum;
                            res_err_d   = (cnt_inc != CNT_TERMS);
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = OUT;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_inc;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State and output registers; handshake flags follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            res_value <= '0;
            res_err   <= 1'b0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            res_value <= res_value_d;
            res_err   <= res_err_d;
            in_ready  <= (state_d == ACCUM);
            res_valid <= (state_d == OUT);
        end
    end

endmodule

// File: tb/tb_mod4051_residue_accumulator.sv
// Directed testbench for mod4051_residue_accumulator.
module tb_mod4051_residue_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_residue;
    logic        in_last;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_value;
    logic        res_err;

    int n_cmp = 0;
    int n_bad = 0;

    mod4051_residue_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_residue (in_residue),
        .in_last    (in_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one beat, wait (bounded) for in_ready, then let it be accepted
    task automatic send_beat(input logic [11:0] v, input logic last);
        int t;
        t = 0;
        in_valid   = 1'b1;
        in_residue = v;
        in_last    = last;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_ready_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_residue = '0;
        in_last = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, res_valid, res_value, res_err} !== {1'b1, 1'b0, 12'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b val=%0d err=%b, required 1 0 0 0",
                     in_ready, res_valid, res_value, res_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        for (int i = 1; i <= 67; i++) send_beat(12'd4050, i == 67);
        n_cmp++;
        if ({res_valid, res_value, res_err, in_ready} !== {1'b1, 12'd3984, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL full_frame_4050: got vld=%b val=%0d err=%b rdy=%b, required 1 3984 0 0",
                     res_valid, res_value, res_err, in_ready);
        end
        consume();
    endtask

    task automatic test_wrap_zero();
        send_beat(12'd2000, 1'b0);
        send_beat(12'd2051, 1'b1);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_zero: got vld=%b val=%0d err=%b, required 1 0 1",
                     res_valid, res_value, res_err);
        end
        consume();
    endtask

    task automatic test_single_beat();
        send_beat(12'd4095, 1'b1);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd44, 1'b1}) begin
            n_bad++;
            $display("FAIL single_beat_4095: got vld=%b val=%0d err=%b, required 1 44 1",
                     res_valid, res_value, res_err);
        end
        consume();
    endtask

    task automatic test_toggle_handoff();
        for (int i = 1; i <= 67; i++) begin
            send_beat(12'(i), i == 67);
            if (i != 67) begin
                // idle cycle with junk on the data lines; acc must hold
                in_residue = 12'd3000;
                in_last    = 1'b1;
                @(posedge clk); #1;
                in_last    = 1'b0;
            end
        end
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd2278, 1'b0}) begin
            n_bad++;
            $display("FAIL toggle_frame: got vld=%b val=%0d err=%b, required 1 2278 0",
                     res_valid, res_value, res_err);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({res_valid, res_value, res_err, in_ready} !== {1'b1, 12'd2278, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_stall_%0d: got vld=%b val=%0d err=%b rdy=%b, required 1 2278 0 0",
                         c, res_valid, res_value, res_err, in_ready);
            end
        end
        consume();
        n_cmp++;
        if ({in_ready, res_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL handoff: got rdy=%b vld=%b, required 1 0", in_ready, res_valid);
        end
        send_beat(12'd5, 1'b1);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL fresh_frame: got vld=%b val=%0d err=%b, required 1 5 1",
                     res_valid, res_value, res_err);
        end
        consume();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 30; i++) send_beat(12'd100, 1'b0);
        // beat presented alongside clr must be dropped
        clr = 1'b1; in_valid = 1'b1; in_residue = 12'd500; in_last = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 1; i <= 67; i++) send_beat(12'd1, i == 67);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd67, 1'b0}) begin
            n_bad++;
            $display("FAIL clr_midframe: got vld=%b val=%0d err=%b, required 1 67 0",
                     res_valid, res_value, res_err);
        end
        // clr in OUT discards the pending result
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_cmp++;
        if ({res_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL clr_in_out: got vld=%b rdy=%b, required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 30; i++) send_beat(12'd100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, res_valid, res_value, res_err} !== {1'b1, 1'b0, 12'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b vld=%b val=%0d err=%b, required 1 0 0 0",
                     in_ready, res_valid, res_value, res_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 67; i++) send_beat(12'd1, i == 67);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd67, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_midframe: got vld=%b val=%0d err=%b, required 1 67 0",
                     res_valid, res_value, res_err);
        end
        consume();
    endtask

    task automatic test_overlength();
        for (int i = 1; i <= 70; i++) send_beat(12'd1, i == 70);
        n_cmp++;
        if ({res_valid, res_value, res_err} !== {1'b1, 12'd70, 1'b1}) begin
            n_bad++;
            $display("FAIL overlength: got vld=%b val=%0d err=%b, required 1 70 1",
                     res_valid, res_value, res_err);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_wrap_zero();
        test_single_beat();
        test_toggle_handoff();
        test_clr();
        test_reset_midframe();
        test_overlength();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod4051_residue_accumulator.md
Name: mod4051_residue_accumulator

Overview:
- Sequential stage directly downstream of the mod-4051 per-chunk LUT bank for the 400-bit operand.
- The 400-bit operand is split into 67 six-bit chunks, and each LUT produces a 12-bit partial residue.
- This block consumes those partial residues as a valid/ready stream, one per cycle, and sums them modulo 4051.
- After the frame's last term it presents the final 12-bit residue of the 400-bit operand, plus a term-count error flag.

Parameters:
- MODULUS, 4051, modulus of the reduction; must satisfy 2^(W-1) < MODULUS < 2^W.
- W, 12, residue width in bits.
- N_TERMS, 67, expected number of partial residues per frame (ceil(400/6)).
- CNT_W, 8, term counter width; must hold N_TERMS+1 without wrapping.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: discards the current frame and any pending result.
- in_valid  input  1  partial residue beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_residue  input  W  partial residue from a LUT stage; nominally < MODULUS.
- in_last  input  1  marks the final beat of a frame.
- res_valid  output  1  final residue available.
- res_ready  input  1  downstream consumes the result.
- res_value  output  W  final residue, always in [0, MODULUS-1].
- res_err  output  1  frame term count was not equal to N_TERMS.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, cnt=0, res_valid=0, res_value=0, res_err=0, in_ready=1.
- Two states:
  - ACCUM: in_ready=1, res_valid=0.
  - OUT: in_ready=0, res_valid=1.
- Beat accepted when in_valid & in_ready.
- Input normalisation, combinational: r = (in_residue >= MODULUS) ? in_residue - MODULUS : in_residue. A single subtraction suffices because 2^W - 1 < 2*MODULUS; for example, 4095 becomes 44.
- Modular add:
  - s = acc + r, computed at W+1 bits.
  - acc_next = (s >= MODULUS) ? s - MODULUS : s.
  - acc is always < MODULUS.
- Counter: cnt_next = cnt + 1, saturating at 2^CNT_W - 1.
- Accepted beat with in_last=0: acc <= acc_next, cnt <= cnt_next, stay in ACCUM.
- Accepted beat with in_last=1:
  - res_value <= acc_next.
  - res_err <= (cnt_next != N_TERMS).
  - acc <= 0, cnt <= 0, go to OUT.
  - res_valid is asserted the cycle after the last beat (1-cycle latency).
- OUT:
  - res_value and res_err are held stable while res_ready=0.
  - On res_ready=1: go to ACCUM; in_ready is 1 from the next cycle.
  - res_value and res_err keep their last values after handoff; they are meaningful only while res_valid=1.
- A single-beat frame (in_last on the first beat) is legal: the result is the normalised r, with res_err=1 unless N_TERMS=1.
- No idle gaps are required; in_valid may toggle freely and acc holds while no beat is accepted.
- clr=1 (synchronous, highest priority after reset):
  - acc=0, cnt=0, state=ACCUM, res_valid=0.
  - A beat presented in the same cycle is dropped.
  - A pending result is discarded.
- Frames longer than N_TERMS keep accumulating. The counter saturates and cannot wrap back to N_TERMS, so res_err=1 at in_last.
- Reset asserted mid-frame or in OUT: the partial sum is lost and the outputs take their reset values immediately.
- No combinational path from in_valid or res_ready to in_ready; in_ready is decoded from the state register only.

Test Plan:
- 67 beats of 4050, last on beat 67 -> one cycle later res_valid=1, res_value=3984, res_err=0.
- Frame of 2 beats (2000, then 2051 with last), N_TERMS=67 -> res_value=0 (wrap exactly to zero), res_err=1.
- Single beat 4095 with last -> res_value=44 (out-of-range input normalised), res_err=1.
- 67 beats of 1, 2, ..., 67 with in_valid toggled every other cycle -> res_value=2278, res_err=0. Then hold res_ready=0 for 10 cycles -> res_valid/res_value stable and in_ready=0; then pulse res_ready -> in_ready=1 next cycle and a new frame starts from acc=0.
- 30 beats of 100, then clr pulse, then 67 beats of 1 -> res_value=67, res_err=0 (first partial frame discarded). Repeat with rst_n pulsed low mid-frame instead of clr -> same result.
- 70 beats of 1, last on beat 70 -> res_value=70, res_err=1 (over-length frame detected).
